// File: rtl/mem_slot_responder.sv
// mem_slot_responder: turns each active 4-clock Mac Plus RAM/ROM bus slot into one req/ack backing-memory transaction, drops slots while busy, flags late acks
module mem_slot_responder #(
    parameter int ROM_BIT = 22,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memoryLatch,
    input  logic [21:0]       memoryAddr,
    input  logic              _romOE,
    input  logic              _ramOE,
    input  logic              _ramWE,
    input  logic              _memoryUDS,
    input  logic              _memoryLDS,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [22:0]       mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              late_err,
    output logic              overrun,
    output logic [DROP_W-1:0] drop_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;
    logic [0:0] state;
    logic       start;
    logic [1:0] age;
    logic       isWrite;
    logic       isRom;
    logic       active;
    logic [22:0] slotAddr;
    always_comb begin
        isWrite = !_ramWE;
        isRom = !isWrite && !_romOE;
        active = isWrite || !_romOE || !_ramOE;
        slotAddr = {1'b0, memoryAddr};
        slotAddr[ROM_BIT] = isRom;
    end
    assign mem_req = state == REQ;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            start <= 1'b0;
            age <= '0;
            dout <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
            late_err <= 1'b0;
            overrun <= 1'b0;
            drop_count <= '0;
        end else begin
            start <= memoryLatch;
            overrun <= 1'b0;
            if (state == IDLE) begin
                if (start && active) begin
                    state <= REQ;
                    age <= '0;
                    mem_addr <= slotAddr;
                    mem_we <= isWrite;
                    mem_be <= {!_memoryUDS, !_memoryLDS};
                    mem_wdata <= din;
                end
            end else begin
                age <= age == 2'd3 ? age : age + 2'd1;
                if (start && active) begin
                    overrun <= 1'b1;
                    drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
                end
                if (mem_ack) begin
                    state <= IDLE;
                    if (!mem_we) dout <= mem_rdata;
                    if (age[1]) late_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_slot_responder.sv
// tb_mem_slot_responder: directed slot sequences checking reads, writes, priority, deadline, drops and reset
module tb_mem_slot_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        memoryLatch;
    logic [21:0] memoryAddr;
    logic        _romOE;
    logic        _ramOE;
    logic        _ramWE;
    logic        _memoryUDS;
    logic        _memoryLDS;
    logic [15:0] din;
    logic [15:0] dout;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        late_err;
    logic        overrun;
    logic [7:0]  drop_count;
    int checks = 0;
    int passes = 0;

    mem_slot_responder #(.ROM_BIT(22), .DROP_W(8)) dut (
        .clk(clk), .reset(reset), .memoryLatch(memoryLatch), .memoryAddr(memoryAddr),
        ._romOE(_romOE), ._ramOE(_ramOE), ._ramWE(_ramWE),
        ._memoryUDS(_memoryUDS), ._memoryLDS(_memoryLDS), .din(din), .dout(dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .late_err(late_err), .overrun(overrun), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input logic l, input logic a);
        memoryLatch = l;
        mem_ack = a;
        @(posedge clk);
        #1;
        memoryLatch = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic strobes(input logic we, input logic rom, input logic ram, input logic uds, input logic lds);
        _ramWE = we;
        _romOE = rom;
        _ramOE = ram;
        _memoryUDS = uds;
        _memoryLDS = lds;
    endtask

    initial begin
        reset = 1'b1;
        memoryLatch = 1'b0;
        memoryAddr = '0;
        din = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        strobes(1, 1, 1, 1, 1);
        cyc(0, 0);
        cyc(0, 0);
        reset = 1'b0;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_late", 32'(late_err), 0);
        chk("rst_drop", 32'(drop_count), 0);
        strobes(1, 1, 0, 0, 0);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("no_slot_before_latch", 32'(mem_req), 0);

        memoryAddr = 22'h001234;
        cyc(1, 0);
        cyc(0, 0);
        chk("ramrd_req_p1", 32'(mem_req), 1);
        chk("ramrd_addr", 32'(mem_addr), 32'h001234);
        chk("ramrd_we", 32'(mem_we), 0);
        chk("ramrd_be", 32'(mem_be), 2'b11);
        cyc(0, 0);
        chk("ramrd_req_p2", 32'(mem_req), 1);
        mem_rdata = 16'hBEEF;
        cyc(0, 1);
        chk("ramrd_dout_p3", 32'(dout), 16'hBEEF);
        chk("ramrd_req_off", 32'(mem_req), 0);
        chk("ramrd_late", 32'(late_err), 0);

        strobes(1, 0, 0, 0, 0);
        memoryAddr = 22'h000400;
        cyc(1, 0);
        cyc(0, 0);
        chk("romrd_addr", 32'(mem_addr), 32'h400400);
        chk("romrd_req", 32'(mem_req), 1);
        mem_rdata = 16'h1111;
        cyc(0, 1);
        chk("romrd_dout", 32'(dout), 16'h1111);
        chk("romrd_late", 32'(late_err), 0);
        cyc(0, 0);

        strobes(0, 0, 0, 1, 0);
        din = 16'hA55A;
        memoryAddr = 22'h000020;
        cyc(1, 0);
        cyc(0, 0);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_be", 32'(mem_be), 2'b01);
        chk("wr_wdata", 32'(mem_wdata), 16'hA55A);
        chk("wr_addr", 32'(mem_addr), 32'h000020);
        mem_rdata = 16'hDEAD;
        cyc(0, 1);
        chk("wr_dout_hold", 32'(dout), 16'h1111);
        chk("wr_req_off", 32'(mem_req), 0);
        cyc(0, 0);

        strobes(1, 1, 0, 0, 0);
        memoryAddr = 22'h000010;
        cyc(1, 0);
        cyc(0, 0);
        chk("late_req", 32'(mem_req), 1);
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 0);
        chk("late_no_ovr_yet", 32'(overrun), 0);
        cyc(0, 0);
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_count", 32'(drop_count), 1);
        chk("ovr_req_kept", 32'(mem_req), 1);
        cyc(0, 0);
        chk("ovr_pulse_end", 32'(overrun), 0);
        mem_rdata = 16'h5678;
        cyc(0, 1);
        chk("late_err_set", 32'(late_err), 1);
        chk("late_dout", 32'(dout), 16'h5678);
        chk("late_req_off", 32'(mem_req), 0);
        strobes(1, 1, 1, 0, 0);
        cyc(1, 0);
        cyc(0, 0);
        chk("dropped_not_issued", 32'(mem_req), 0);
        chk("late_sticky", 32'(late_err), 1);
        cyc(0, 0);
        cyc(0, 0);

        strobes(1, 1, 0, 0, 0);
        for (int i = 0; i < 301; i++) begin
            cyc(1, 0);
            cyc(0, 0);
            cyc(0, 0);
            cyc(0, 0);
        end
        chk("sat_count", 32'(drop_count), 8'hFF);
        chk("sat_req_held", 32'(mem_req), 1);

        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        chk("rstmid_req", 32'(mem_req), 0);
        chk("rstmid_dout", 32'(dout), 0);
        chk("rstmid_late", 32'(late_err), 0);
        chk("rstmid_drop", 32'(drop_count), 0);
        mem_rdata = 16'h9999;
        cyc(0, 1);
        chk("stale_ack_dout", 32'(dout), 0);
        chk("stale_ack_req", 32'(mem_req), 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("rstmid_no_req", 32'(mem_req), 0);
        cyc(1, 0);
        cyc(0, 0);
        chk("rstmid_recover_req", 32'(mem_req), 1);
        chk("rstmid_recover_addr", 32'(mem_addr), 32'h000010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
